// File: rtl/div_seq_capture.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_capture
//  Description : Sequencer and result-capture stage around the combinational
//                restoring divider. Registers operand magnitudes, waits a
//                programmable number of cycles for the divider to settle,
//                applies the signed correction and captures quotient (ZLow)
//                and remainder (ZHigh). Handles divide-by-zero directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_capture #(
    parameter int SETTLE_CYCLES = 4,   // legal range 1..15
    parameter int WIDTH         = 32   // only 32 is supported
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic [WIDTH-1:0] zlow,
    output logic [WIDTH-1:0] zhigh,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_wait    = 1'b1;
    localparam logic [3:0] c_count_load = 4'(SETTLE_CYCLES - 1);

    logic [0:0]       r_state;
    logic [3:0]       r_count;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_zlow;
    logic [WIDTH-1:0] r_zhigh;
    logic             r_done;
    logic             r_dbz;
    logic             r_q_neg;
    logic             r_r_neg;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_dvs_zero;

    // Operand magnitudes for the unsigned divider; the most negative value
    // negates to itself, which the divider then treats as 2^31.
    always_comb begin
        w_dvd_mag = dividend_in;
        w_dvs_mag = divisor_in;
        if (div_signed && dividend_in[WIDTH-1]) begin
            w_dvd_mag = -dividend_in;
        end
        if (div_signed && divisor_in[WIDTH-1]) begin
            w_dvs_mag = -divisor_in;
        end
    end

    // Sign correction of the settled divider outputs (32-bit wraparound).
    always_comb begin
        w_q_fix = r_q_neg ? -div_quotient  : div_quotient;
        w_r_fix = r_r_neg ? -div_remainder : div_remainder;
    end

    assign w_dvs_zero = (divisor_in == '0);

    // Sequencer: accept in IDLE, count down the settle window, then capture.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= c_st_idle;
            r_count    <= 4'd0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_zlow     <= '0;
            r_zhigh    <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_dividend <= w_dvd_mag;
                        r_divisor  <= w_dvs_mag;
                        r_q_neg    <= div_signed & (dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1]);
                        r_r_neg    <= div_signed & dividend_in[WIDTH-1];
                        if (w_dvs_zero) begin
                            // Divide-by-zero completes immediately with the raw dividend.
                            r_zlow  <= '1;
                            r_zhigh <= dividend_in;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_count <= c_count_load;
                            r_state <= c_st_wait;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        r_zlow  <= w_q_fix;
                        r_zhigh <= w_r_fix;
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;
    assign zlow         = r_zlow;
    assign zhigh        = r_zhigh;
    assign busy         = (r_state == c_st_wait);
    assign done         = r_done;
    assign dbz          = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq_capture
//  Description : Scoreboard bench for div_seq_capture. Directed and random
//                divide requests; expected results from a 64-bit arithmetic
//                reference, checked by an independent monitor on done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq_capture;

    localparam int c_settle = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend_in = '0;
    logic [31:0] divisor_in = '0;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic [31:0] zlow;
    logic [31:0] zhigh;
    logic        busy;
    logic        done;
    logic        dbz;

    div_seq_capture #(.SETTLE_CYCLES(c_settle), .WIDTH(32)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .div_signed   (div_signed),
        .dividend_in  (dividend_in),
        .divisor_in   (divisor_in),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .zlow         (zlow),
        .zhigh        (zhigh),
        .busy         (busy),
        .done         (done),
        .dbz          (dbz)
    );

    // Combinational unsigned divider the stage is wrapped around.
    assign div_quotient  = (div_divisor == 32'd0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
    assign div_remainder = (div_divisor == 32'd0) ? div_dividend  : div_dividend % div_divisor;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    // Reference state of the block as seen from outside.
    int          busy_end = 0;   // last edge at which the block is still busy
    int          acc_edge = 0;   // busy window for the monitor: [acc_edge, cap_edge)
    int          cap_edge = 0;
    logic [31:0] m_dd = '0;
    logic [31:0] m_dv = '0;
    logic        m_dbz = 1'b0;
    logic [31:0] m_zlow = '0;
    logic [31:0] m_zhigh = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb_;
        z = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
            q = 32'(sa / sb_);
            r = 32'(sa % sb_);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [31:0] mag(input bit sgn, input logic [31:0] x);
        return (sgn && x[31]) ? 32'd0 - x : x;
    endfunction

    // Issue one start pulse; the reference decides whether it is accepted.
    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int   e;
        bit   acc;
        exp_t x;
        @(negedge clk);
        start = 1'b1;
        div_signed = sgn;
        dividend_in = a;
        divisor_in = b;
        e = cyc + 1;
        acc = (e > busy_end);
        if (acc) begin
            ref_div(sgn, a, b, x.q, x.r, x.z);
            x.due = (b == 32'd0) ? e : e + c_settle;
            sb.push_back(x);
            busy_end = x.due;
            if (b != 32'd0) begin
                acc_edge = e;
                cap_edge = x.due;
            end
            m_dd = mag(sgn, a);
            m_dv = mag(sgn, b);
            m_dbz = (b == 32'd0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend_in = $urandom;
        divisor_in = $urandom;
        chk("div_dividend", div_dividend, m_dd);
        chk("div_divisor", div_divisor, m_dv);
        if (!(acc && b == 32'd0)) chk("dbz", {31'd0, dbz}, {31'd0, m_dbz});
    endtask

    task automatic wait_idle();
        while (cyc < busy_end) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        #1;
        sb.delete();
        busy_end = 0;
        acc_edge = 0;
        cap_edge = 0;
        m_dd = '0;
        m_dv = '0;
        m_dbz = 1'b0;
        m_zlow = '0;
        m_zhigh = '0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dbz", {31'd0, dbz}, 32'd0);
        chk("rst_zlow", zlow, 32'd0);
        chk("rst_zhigh", zhigh, 32'd0);
        chk("rst_div_dividend", div_dividend, 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Monitor: busy window, done pulses against the scoreboard, result holding.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            chk("busy", {31'd0, busy}, {31'd0, (cyc >= acc_edge && cyc < cap_edge)});
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    x = sb.pop_front();
                    chk("done_cycle", cyc, x.due);
                    chk("zlow", zlow, x.q);
                    chk("zhigh", zhigh, x.r);
                    chk("done_dbz", {31'd0, dbz}, {31'd0, x.z});
                    m_zlow = x.q;
                    m_zhigh = x.r;
                end
            end else begin
                if (sb.size() != 0 && sb[0].due < cyc) begin
                    x = sb.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missing_done: got no done expected at cycle %0d (now %0d)", x.due, cyc);
                end
                chk("zlow_hold", zlow, m_zlow);
                chk("zhigh_hold", zhigh, m_zhigh);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        bit          s;
        do_reset();

        // Directed cases.
        issue(1'b0, 32'd100, 32'd7);
        wait_idle();
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_idle();
        issue(1'b0, 32'h1234, 32'd0);
        wait_idle();
        issue(1'b0, 32'd20, 32'd6);              // clears dbz
        wait_idle();
        issue(1'b0, 32'd50, 32'd5);
        @(negedge clk);
        issue(1'b0, 32'd9, 32'd3);               // ignored while busy
        wait_idle();
        issue(1'b0, 32'd100, 32'd7);
        do_reset();                              // abort mid-operation
        issue(1'b0, 32'd100, 32'd7);
        wait_idle();
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_idle();
        issue(1'b1, 32'hFFFF_FF00, 32'd0);       // back-to-back in done cycle
        issue(1'b1, 32'h8000_0000, 32'd3);
        wait_idle();
        issue(1'b0, 32'd1000, 32'd33);

        // Random traffic, including starts that land while busy.
        for (int i = 0; i < 60; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 500));
            if ($urandom_range(0, 2) != 0) wait_idle();
            issue(s, a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
